// File: rtl/irq_timer.sv
`default_nettype none
// ============================================================================
// Module   : irq_timer
// Purpose  : Memory-mapped down-counter timer with interrupt output. The CPU
//            programs CTRL/PRESET with stores and reads COUNT with loads.
//            Supports a one-shot mode, where the interrupt is sticky, and an
//            auto-reload mode, where the interrupt is a one-cycle pulse.
// Ports    : clk   - system clock, rising edge
//            reset - synchronous, active-high reset
//            addr  - word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
//            we    - write strobe, sampled at the rising edge
//            din   - write data (PRESET truncated to CNT_W)
//            dout  - combinational read data for addr (COUNT zero-extended)
//            irq   - interrupt request (pend & CTRL.IM)
// CTRL     : [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x = 00),
//            [3] IM, [7:4] P (prescaler exponent, only with TIMER_PRESCALE_EN)
// Options  : TIMER_PRESCALE_EN - when defined, CTRL[7:4] becomes writable and
//            COUNT only steps once every 2^P cycles spent in the CNT state.
// Revision : 1.0 - initial release
// ============================================================================
module irq_timer #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

`ifdef TIMER_PRESCALE_EN
  localparam logic [7:0] CTRL_WMASK = 8'hFF;
`else
  localparam logic [7:0] CTRL_WMASK = 8'h0F;
`endif

  state_t           state_q;
  logic [7:0]       ctrl_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic             pend_q;

  logic             w_en;
  logic             w_autoreload;
  logic             w_tick;
  logic             w_wr_ctrl;
  logic             w_wr_preset;
  logic             w_pend_set;
  logic             w_unused_din;

  assign w_en         = ctrl_q[0];
  // Only MODE=01 reloads; the reserved 1x encodings behave as one-shot.
  assign w_autoreload = (ctrl_q[2:1] == 2'b01);
  assign w_wr_ctrl    = we && (addr == ADDR_CTRL);
  assign w_wr_preset  = we && (addr == ADDR_PRESET);

  // Terminal count reached while still enabled: the FSM enters INT.
  assign w_pend_set   = (state_q == S_CNT) && w_en && w_tick && (count_q == '0);

  // Upper write-data bits beyond CTRL/PRESET width carry no meaning.
  assign w_unused_din = ^din;

`ifdef TIMER_PRESCALE_EN
  logic [14:0] presc_q;
  logic [14:0] w_presc_max;

  // 2^P - 1 computed in 16 bits so P=15 does not overflow before the -1.
  assign w_presc_max = 15'((16'd1 << ctrl_q[7:4]) - 16'd1);
  assign w_tick      = (presc_q == w_presc_max);

  // Prescaler only advances while actually counting; any other state
  // (including leaving CNT through EN=0) returns it to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else if ((state_q == S_CNT) && w_en && !w_tick) begin
      presc_q <= presc_q + 15'd1;
    end else begin
      presc_q <= '0;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Control FSM, counter and bus-visible registers.
  // Statement order encodes the collision rules: the CPU CTRL write is placed
  // after the INT-state EN clear so it wins, and the FSM pend set is placed
  // after the write-triggered pend clear so the set wins.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_en) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          count_q <= preset_q;
          state_q <= S_CNT;
        end
        S_CNT: begin
          if (!w_en) begin
            state_q <= S_IDLE;
          end else if (w_tick) begin
            // Zero is tested first, so the decrement can never wrap.
            if (count_q != '0) begin
              count_q <= count_q - CNT_W'(1);
            end else begin
              state_q <= S_INT;
            end
          end
        end
        S_INT: begin
          if (w_autoreload) begin
            pend_q  <= 1'b0;
            state_q <= S_LOAD;
          end else begin
            ctrl_q[0] <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (w_wr_ctrl) begin
        ctrl_q <= din[7:0] & CTRL_WMASK;
      end
      if (w_wr_preset) begin
        preset_q <= din[CNT_W-1:0];
      end
      if (w_wr_ctrl || w_wr_preset) begin
        pend_q <= 1'b0;
      end

      if (w_pend_set) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Read mux: reserved bits and the reserved address read as zero.
  always_comb begin
    dout = 32'd0;
    case (addr)
      ADDR_CTRL:   dout = {24'd0, ctrl_q};
      ADDR_PRESET: dout = 32'(preset_q);
      ADDR_COUNT:  dout = 32'(count_q);
      default:     dout = 32'd0;
    endcase
  end

  assign irq = pend_q & ctrl_q[3];

endmodule
`default_nettype wire
